ro_freq_meter: RTL and testbench



---
 rtl/ro_freq_meter.sv | 186 ++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: multi-channel frequency meter for on-die ring oscillators.
// Every oscillator tap is synchronized into the clock domain. The selected
// channel's rising edges are counted over a gate window of 2^GATE_LOG2
// clock cycles, and the result is latched for the readout mux. Measurements
// can be single-shot or continuous (back-to-back windows).
//
// Ports:
//   i_clk        - single clock, all logic on the rising edge
//   i_rst        - synchronous active-high reset
//   i_ena        - design enable; low aborts any measurement
//   i_ro_in      - asynchronous oscillator taps, one bit per channel
//   i_ch_sel     - channel to measure, sampled when a window is armed
//   i_start      - level-sampled request to begin a measurement
//   i_continuous - 1 = run back-to-back windows until cleared
//   o_busy       - high in every state except IDLE
//   o_done       - one-cycle pulse when o_count updates
//   o_count      - last completed result
//   o_overflow   - last result saturated
//   o_ch_out     - channel that produced o_count
module ro_freq_meter #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_LOG2   = 10,
  parameter int SYNC_STAGES = 2,
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ena,
  input  logic [CHANNELS-1:0] i_ro_in,
  input  logic [SW-1:0]       i_ch_sel,
  input  logic                i_start,
  input  logic                i_continuous,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_overflow,
  output logic [SW-1:0]       o_ch_out
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SYNC_STAGES);
  localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SW:0] CH_LIMIT = (SW + 1)'(CHANNELS);
  localparam int PAD_W = 1 << SW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    LATCH  = 2'd3
  } state_t;

  state_t                               r_state;
  state_t                               w_stateNext;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_prev;
  logic [CHANNELS-1:0]                  w_synced;
  logic [PAD_W-1:0]                     w_risePad;
  logic                                 w_rise;
  logic [SW-1:0]                        w_selSafe;
  logic [SW-1:0]                        r_curCh;
  logic [SETTLE_W-1:0]                  r_settle;
  logic [GATE_LOG2-1:0]                 r_gateTimer;
  logic [CNT_W-1:0]                     r_counter;
  logic                                 r_sat;
  logic                                 w_arm;
  logic                                 w_gateStart;
  logic                                 r_done;
  logic [CNT_W-1:0]                     r_count;
  logic                                 r_overflow;
  logic [SW-1:0]                        r_chOut;

  // Rising edges of every synchronized channel; padded to a power of two so
  // indexing by the channel register can never fall outside the vector.
  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_risePad = PAD_W'(w_synced & ~r_prev);
  assign w_rise    = w_risePad[r_curCh];

  // An out-of-range selection is folded onto channel 0.
  assign w_selSafe = ({1'b0, i_ch_sel} < CH_LIMIT) ? i_ch_sel : '0;

  // Next-state logic. Losing enable anywhere outside IDLE aborts to IDLE;
  // LATCH itself still completes because the output latch does not look
  // at enable.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (i_start && i_ena) w_stateNext = SETTLE;
      end
      SETTLE: begin
        if (!i_ena)                w_stateNext = IDLE;
        else if (r_settle == '0)   w_stateNext = GATE;
      end
      GATE: begin
        if (!i_ena)                      w_stateNext = IDLE;
        else if (r_gateTimer == GATE_LAST) w_stateNext = LATCH;
      end
      LATCH: begin
        if (i_continuous && i_ena)
          w_stateNext = (w_selSafe == r_curCh) ? GATE : SETTLE;
        else
          w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Arming a window (from IDLE or from LATCH with a new channel) and
  // entering the gate are both detected from the state transition.
  assign w_arm       = (w_stateNext == SETTLE) && (r_state != SETTLE);
  assign w_gateStart = (w_stateNext == GATE) && (r_state != GATE);

  // Synchronizers and edge history run continuously on all channels so a
  // newly selected channel only needs a short settle period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro_in};
      r_prev <= w_synced;
    end
  end

  // State register, settle/gate timers and the saturating edge counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_curCh     <= '0;
      r_settle    <= '0;
      r_gateTimer <= '0;
      r_counter   <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_arm) begin
        r_curCh   <= w_selSafe;
        r_settle  <= SETTLE_LOAD;
        r_counter <= '0;
        r_sat     <= 1'b0;
      end else if (r_state == SETTLE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end
      if (w_gateStart) begin
        r_gateTimer <= '0;
        r_counter   <= '0;
        r_sat       <= 1'b0;
      end else if (r_state == GATE) begin
        r_gateTimer <= r_gateTimer + 1'b1;
        if (w_rise) begin
          if (r_counter == CNT_MAX) r_sat <= 1'b1;
          else                      r_counter <= r_counter + 1'b1;
        end
      end
    end
  end

  // Result latch: only the LATCH state updates the visible result, so an
  // aborted window leaves the previous result untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_chOut    <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == LATCH) begin
        r_done     <= 1'b1;
        r_count    <= r_counter;
        r_overflow <= r_sat;
        r_chOut    <= r_curCh;
      end
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_ch_out   = r_chOut;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Testbench for ro_freq_meter. Three instances share clock, reset, enable,
// continuous and the oscillator taps: a main meter (CHANNELS=4, CNT_W=8),
// a narrow-counter meter (CNT_W=3) for saturation, and a three-channel
// meter for out-of-range channel selection. Every start pushes the expected
// result and done cycle into a per-instance queue; monitors pop and compare
// whenever done is seen.
module tb_ro_freq_meter;

  // With SYNC_STAGES=2 and GATE_LOG2=4: start-to-done is 2+2+16 cycles,
  // and continuous same-channel windows repeat every 16+1 cycles.
  localparam int LAT       = 20;
  localparam int CONT_STEP = 17;

  typedef struct {
    int count;
    int ovf;
    int ch;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       continuous;
  logic [3:0] ro = '0;
  logic       start1, start2, start3;
  logic [1:0] sel1, sel2, sel3;

  logic       busy1, done1, ovf1;
  logic [7:0] count1;
  logic [1:0] chOut1;
  logic       busy2, done2, ovf2;
  logic [2:0] count2;
  logic [1:0] chOut2;
  logic       busy3, done3, ovf3;
  logic [7:0] count3;
  logic [1:0] chOut3;

  int   cyc    = 0;
  int   tick   = 0;
  int   period [4];
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  ro_freq_meter #(.CHANNELS(4), .CNT_W(8), .GATE_LOG2(4), .SYNC_STAGES(2)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ro_in(ro), .i_ch_sel(sel1),
    .i_start(start1), .i_continuous(continuous), .o_busy(busy1), .o_done(done1),
    .o_count(count1), .o_overflow(ovf1), .o_ch_out(chOut1)
  );

  ro_freq_meter #(.CHANNELS(4), .CNT_W(3), .GATE_LOG2(4), .SYNC_STAGES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ro_in(ro), .i_ch_sel(sel2),
    .i_start(start2), .i_continuous(1'b0), .o_busy(busy2), .o_done(done2),
    .o_count(count2), .o_overflow(ovf2), .o_ch_out(chOut2)
  );

  ro_freq_meter #(.CHANNELS(3), .CNT_W(8), .GATE_LOG2(4), .SYNC_STAGES(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_ro_in(ro[2:0]), .i_ch_sel(sel3),
    .i_start(start3), .i_continuous(1'b0), .o_busy(busy3), .o_done(done3),
    .o_count(count3), .o_overflow(ovf3), .o_ch_out(chOut3)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge N, cyc reads N at the following negedge.
  always @(posedge clk) cyc++;

  // Oscillator taps driven synchronously; period 0 holds the tap low.
  always @(negedge clk) begin
    tick++;
    for (int c = 0; c < 4; c++)
      ro[c] = (period[c] != 0) && ((tick % period[c]) < (period[c] / 2));
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic scoreCheck(input string tag, input exp_t e, input int cnt,
                            input int ovf, input int ch);
    checkOutput({tag, " count"}, cnt, e.count);
    checkOutput({tag, " overflow"}, ovf, e.ovf);
    checkOutput({tag, " ch_out"}, ch, e.ch);
    checkOutput({tag, " done cycle"}, cyc, e.cyc);
  endtask

  // Scoreboard monitors: a done with nothing queued is itself a failure.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) checkOutput("dut1 unexpected done", int'(done1), 0);
      else scoreCheck("dut1", q1.pop_front(), int'(count1), int'(ovf1), int'(chOut1));
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) checkOutput("dut2 unexpected done", int'(done2), 0);
      else scoreCheck("dut2", q2.pop_front(), int'(count2), int'(ovf2), int'(chOut2));
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) checkOutput("dut3 unexpected done", int'(done3), 0);
      else scoreCheck("dut3", q3.pop_front(), int'(count3), int'(ovf3), int'(chOut3));
    end
  end

  // Issues a one-cycle start to one instance and queues its expected result.
  task automatic applyStimulus(input int dutId, input int ch, input int expCount,
                               input int expOvf, input int expCh);
    exp_t e;
    e = '{expCount, expOvf, expCh, cyc + 1 + LAT};
    case (dutId)
      1: begin q1.push_back(e); sel1 = 2'(ch); start1 = 1'b1; end
      2: begin q2.push_back(e); sel2 = 2'(ch); start2 = 1'b1; end
      default: begin q3.push_back(e); sel3 = 2'(ch); start3 = 1'b1; end
    endcase
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    rst = 1'b1; ena = 1'b1; continuous = 1'b0;
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    sel1 = '0; sel2 = '0; sel3 = '0;
    period[0] = 0; period[1] = 2; period[2] = 4; period[3] = 4;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset busy", int'(busy1), 0);
    checkOutput("reset done", int'(done1), 0);
    checkOutput("reset count", int'(count1), 0);
    checkOutput("reset overflow", int'(ovf1), 0);
    checkOutput("reset ch_out", int'(chOut1), 0);
    checkOutput("reset busy dut2", int'(busy2), 0);
    checkOutput("reset busy dut3", int'(busy3), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single shot on channel 2 (period 4): 4 edges in 16 cycles
    c = cyc;
    applyStimulus(1, 2, 4, 0, 2);
    checkOutput("busy after start", int'(busy1), 1);
    waitUntil(c + LAT + 3);
    checkOutput("busy back to idle", int'(busy1), 0);
    checkOutput("pending ch2", q1.size(), 0);

    // Single shot on static channel 0
    c = cyc;
    applyStimulus(1, 0, 0, 0, 0);
    waitUntil(c + LAT + 3);
    checkOutput("pending ch0", q1.size(), 0);

    // Saturation with a 3-bit counter: 8 edges clamp to 7 with overflow
    c = cyc;
    applyStimulus(2, 1, 7, 1, 1);
    waitUntil(c + LAT + 3);
    period[1] = 0;
    repeat (4) @(negedge clk);
    c = cyc;
    applyStimulus(2, 1, 0, 0, 1);
    waitUntil(c + LAT + 3);
    checkOutput("pending sat", q2.size(), 0);

    // Continuous on ch 3, then switch to ch 1 (period 8), then stop
    period[1] = 8;
    repeat (4) @(negedge clk);
    c = cyc + 1;
    q1.push_back('{4, 0, 3, c + LAT});
    q1.push_back('{4, 0, 3, c + LAT + CONT_STEP});
    q1.push_back('{4, 0, 3, c + LAT + 2 * CONT_STEP});
    q1.push_back('{2, 0, 1, c + LAT + 2 * CONT_STEP + LAT});
    sel1 = 2'd3; continuous = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitUntil(c + 30);
    checkOutput("continuous busy", int'(busy1), 1);
    waitUntil(c + 45);
    sel1 = 2'd1;
    waitUntil(c + 65);
    continuous = 1'b0;
    waitUntil(c + 77);
    checkOutput("continuous stopped", int'(busy1), 0);
    checkOutput("pending continuous", q1.size(), 0);

    // Start pulsed during GATE is ignored, and ch_sel changes do not matter
    c = cyc;
    applyStimulus(1, 2, 4, 0, 2);
    waitUntil(c + 8);
    sel1 = 2'd0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitUntil(c + LAT + 20);
    checkOutput("pending ignored start", q1.size(), 0);

    // Enable dropped mid-GATE: abort without done, result retained
    c = cyc;
    sel1 = 2'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitUntil(c + 10);
    ena = 1'b0;
    @(negedge clk);
    checkOutput("ena abort busy", int'(busy1), 0);
    ena = 1'b1;
    waitUntil(c + LAT + 15);
    checkOutput("ena abort count kept", int'(count1), 4);
    checkOutput("ena abort ch_out kept", int'(chOut1), 2);

    // Reset mid-GATE clears everything
    c = cyc;
    sel1 = 2'd2; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waitUntil(c + 10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid rst busy", int'(busy1), 0);
    checkOutput("mid rst done", int'(done1), 0);
    checkOutput("mid rst count", int'(count1), 0);
    checkOutput("mid rst overflow", int'(ovf1), 0);
    checkOutput("mid rst ch_out", int'(chOut1), 0);
    rst = 1'b0;
    repeat (LAT + 5) @(negedge clk);

    // Out-of-range channel 3 on a 3-channel meter measures ch 0 (period 8)
    period[0] = 8;
    repeat (4) @(negedge clk);
    c = cyc;
    applyStimulus(3, 3, 2, 0, 0);
    waitUntil(c + LAT + 3);
    checkOutput("pending out-of-range", q3.size(), 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
